dmem_bus: RTL
=============

// Module: dmem_bus
// PURPOSE
//  Parametrised byte-addressed big-endian data memory with a valid/ready request/response handshake.
//  Supports byte/half/word loads and stores, optional sign extension and configurable access latency.
//  Flags misaligned, out-of-range and reserved-size accesses.
//  Sits between the core's load/store stage and backing storage; benches preload mem[] via $readmemh.
// PARAMETERS
//  SIZE     16384  memory depth in bytes (mem[0:SIZE-1], 8 bits each)
//  AW       32     request address width
//  LATENCY  2      cycles from request accept edge to resp_valid rise; legal range >=1
// PORTS
//  clk         in   1     clock; all state updates on the rising edge
//  rst_n       in   1     asynchronous, active-low reset
//  req_valid   in   1     request present
//  req_ready   out  1     block can accept a request (state IDLE)
//  req_write   in   1     1=store, 0=load
//  req_size    in   [0:1] 00=byte, 01=half, 10=word, 11=reserved
//  req_signed  in   1     sign-extend load data (ignored for word and for stores)
//  req_addr    in   [0:AW-1] byte address; bit AW-1 is the LSB
//  req_wdata   in   [0:31] store data, right-justified (byte=[24:31], half=[16:31])
//  resp_valid  out  1     response present
//  resp_ready  in   1     consumer accepts response
//  resp_rdata  out  [0:31] load data, right-justified; 0 for stores and faults
//  resp_fault  out  1     access faulted
// BEHAVIOUR
//  - One clock; rst_n is asynchronous and active-low. Assertion forces IDLE immediately.
//  - Reset values: resp_valid=0, resp_rdata=0, resp_fault=0, req_ready=1 (req_ready = state==IDLE).
//  - Reset does not clear mem[].
//  - FSM states: IDLE, WAIT, RESP.
//  - IDLE: on req_valid&&req_ready, latch all req_* fields and compute the fault.
//      LATENCY==1 -> go to RESP; otherwise go to WAIT with cnt=LATENCY-2.
//  - WAIT: cnt decrements each cycle. On the edge where cnt==0, go to RESP.
//  - Entry to RESP (the edge that raises resp_valid):
//      store commits to mem[], or load data is captured into resp_rdata.
//      Both happen only if there is no fault.
//  - Result: resp_valid rises exactly LATENCY cycles after the accept edge.
//  - RESP: resp_valid=1. resp_rdata and resp_fault are held stable until resp_valid&&resp_ready.
//      On that edge go to IDLE and clear resp_valid, resp_rdata and resp_fault to 0.
//      req_ready returns 1 the following cycle; no same-cycle turnaround.
//  - Requests presented outside IDLE are ignored (req_ready=0). Exactly one access is outstanding at a time.
//  - Byte order is big-endian: mem[a] is most significant.
//      Word at a = {mem[a], mem[a+1], mem[a+2], mem[a+3]}; half = {mem[a], mem[a+1]}.
//  - Load extension: zero-extend byte/half when req_signed=0; sign-extend from the top bit of the loaded item when 1.
//  - Fault conditions (resp_fault=1):
//      size=11;
//      half with addr[AW-1]=1;
//      word with addr[AW-2:AW-1]!=0;
//      addr+nbytes > SIZE (compute in AW+1 bits, so no wrap-around).
//  - On fault: no mem write, resp_rdata=0, same latency and handshake as a good access.
//  - Reset asserted in WAIT or RESP: the access is abandoned; a store still in WAIT never commits.
// TESTING
//  1. Reset; store word 0xDEADBEEF @0x2000 -> resp_valid exactly 2 cycles after accept, fault=0;
//     mem[0x2000]=DE, mem[0x2003]=EF; word load @0x2000 -> 0xDEADBEEF.
//  2. Byte load @0x2001: unsigned -> 0x000000AD, signed -> 0xFFFFFFAD;
//     half load @0x2002 signed -> 0xFFFFBEEF; store byte 0x5A @0x2003 -> word reads 0xDEADBE5A.
//  3. Word load @0x2002, half load @0x2001 and size=11 each -> resp_fault=1, rdata=0;
//     a faulting store leaves mem unchanged.
//  4. Word load @SIZE-4 -> ok; word @SIZE-2 (misaligned) and half @SIZE-1 -> fault.
//     Address 0xFFFFFFFC (AW=32) -> fault, no wrap.
//  5. Hold resp_ready=0 for 5 cycles with req_valid=1 -> resp_valid, rdata and fault stable, req_ready=0,
//     no second access; resp_ready=1 -> IDLE, then the next request is accepted.
//  6. Accept store 0x11223344 @0x100, pulse rst_n low in WAIT -> outputs 0 at once, mem[0x100..0x103] unchanged,
//     req_ready=1 after release. Repeat with LATENCY=1 and LATENCY=5 to check timing.

Source files
------------

// File: rtl/dmem_bus.sv
// Big-endian byte-addressed data memory behind a single-outstanding valid/ready
// request/response handshake with configurable access latency and fault flagging.
module dmem_bus #(
  parameter int SIZE    = 16384,
  parameter int AW      = 32,
  parameter int LATENCY = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_write,
  input  logic [0:1]    req_size,
  input  logic          req_signed,
  input  logic [0:AW-1] req_addr,
  input  logic [0:31]   req_wdata,
  output logic          resp_valid,
  input  logic          resp_ready,
  output logic [0:31]   resp_rdata,
  output logic          resp_fault
);

  localparam int IW = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam int CW = (LATENCY > 2) ? $clog2(LATENCY) : 1;
  localparam logic [AW:0] SIZE_L = (AW+1)'(SIZE);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [7:0]    mem [0:SIZE-1];

  logic          wr_q, sgn_q;
  logic [0:1]    size_q;
  logic [0:AW-1] addr_q;
  logic [0:31]   wdata_q;

  logic          accept, enter_resp;
  logic          sel_wr, sel_sgn;
  logic [0:1]    sel_size;
  logic [0:AW-1] sel_addr;
  logic [0:31]   sel_wdata;
  logic [AW:0]   nbytes, last;
  logic          fault;
  logic [IW-1:0] a0, a1, a2, a3;
  logic [7:0]    b0, b1, b2, b3;
  logic [0:31]   ldata;

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);
  assign accept     = req_valid && req_ready;

  // With LATENCY==1 the access completes on the accept edge, so the live
  // request fields are used in IDLE and the latched copy otherwise.
  assign sel_wr    = (state == IDLE) ? req_write  : wr_q;
  assign sel_sgn   = (state == IDLE) ? req_signed : sgn_q;
  assign sel_size  = (state == IDLE) ? req_size   : size_q;
  assign sel_addr  = (state == IDLE) ? req_addr   : addr_q;
  assign sel_wdata = (state == IDLE) ? req_wdata  : wdata_q;

  always_comb begin
    nbytes = (AW+1)'(4);
    case (sel_size)
      2'b00:   nbytes = (AW+1)'(1);
      2'b01:   nbytes = (AW+1)'(2);
      default: nbytes = (AW+1)'(4);
    endcase
    // One extra bit keeps addresses near the top of the space from wrapping.
    last  = {1'b0, sel_addr} + nbytes;
    fault = (sel_size == 2'b11) ||
            ((sel_size == 2'b01) && sel_addr[AW-1]) ||
            ((sel_size == 2'b10) && (sel_addr[AW-2:AW-1] != 2'b00)) ||
            (last > SIZE_L);
  end

  assign a0 = sel_addr[AW-IW:AW-1];
  assign a1 = a0 + IW'(1);
  assign a2 = a0 + IW'(2);
  assign a3 = a0 + IW'(3);
  assign b0 = mem[a0];
  assign b1 = mem[a1];
  assign b2 = mem[a2];
  assign b3 = mem[a3];

  always_comb begin
    ldata = '0;
    case (sel_size)
      2'b00:   ldata = {{24{sel_sgn & b0[7]}}, b0};
      2'b01:   ldata = {{16{sel_sgn & b0[7]}}, b0, b1};
      2'b10:   ldata = {b0, b1, b2, b3};
      default: ldata = '0;
    endcase
  end

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    enter_resp = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (LATENCY == 1) begin
            state_n    = RESP;
            enter_resp = 1'b1;
          end else begin
            state_n = WAIT;
            cnt_n   = CW'(LATENCY - 2);
          end
        end
      end
      WAIT: begin
        if (cnt == '0) begin
          state_n    = RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      RESP: begin
        if (resp_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // control and response registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      resp_rdata <= '0;
      resp_fault <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (enter_resp) begin
        resp_fault <= fault;
        resp_rdata <= (fault || sel_wr) ? '0 : ldata;
      end else if ((state == RESP) && resp_ready) begin
        resp_fault <= 1'b0;
        resp_rdata <= '0;
      end
    end
  end

  // request capture
  always_ff @(posedge clk) begin
    if (accept) begin
      wr_q    <= req_write;
      sgn_q   <= req_signed;
      size_q  <= req_size;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
    end
  end

  // store commit on entry to RESP; storage is never reset
  always_ff @(posedge clk) begin
    if (enter_resp && sel_wr && !fault) begin
      case (sel_size)
        2'b00: mem[a0] <= sel_wdata[24:31];
        2'b01: begin
          mem[a0] <= sel_wdata[16:23];
          mem[a1] <= sel_wdata[24:31];
        end
        default: begin
          mem[a0] <= sel_wdata[0:7];
          mem[a1] <= sel_wdata[8:15];
          mem[a2] <= sel_wdata[16:23];
          mem[a3] <= sel_wdata[24:31];
        end
      endcase
    end
  end

endmodule
